// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive path: receiver FSM
//                state encoding, oversampling ratio, the tick indices at which
//                a bit is sampled, and the baud-divider rounding helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM states. ST_PARITY is only reachable when the
  // receiver is built with UART_RX_PARITY_EN.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  localparam int UART_OVERSAMPLE = 16;

  // Oversample tick indices (within one bit) used for the 3-sample majority
  // vote. The bit decision is taken on the last of the three.
  localparam logic [3:0] SAMPLE_TICK_0 = 4'd7;
  localparam logic [3:0] SAMPLE_TICK_1 = 4'd8;
  localparam logic [3:0] SAMPLE_TICK_2 = 4'd9;

  // Rounded clocks-per-oversample-tick: round(clk_hz / (16 * baud)).
  function automatic int uart_div_round(input int clk_hz, input int baud);
    int den;
    den = UART_OVERSAMPLE * baud;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Small synchronous byte FIFO for received characters with a
//                registered head entry and registered valid flag.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk_i        in   system clock, rising edge
//    reset_i      in   synchronous active-high reset
//    push_i       in   write push_data_i (ignored when full without a pop)
//    push_data_i  in   [7:0] byte to write
//    pop_i        in   remove the head entry (ignored when empty)
//    full_o       out  FIFO holds DEPTH entries
//    empty_o      out  FIFO holds no entries
//    valid_o      out  registered not-empty flag
//    head_o       out  [7:0] registered head entry
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       valid_o,
  output logic [7:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          valid_q, valid_d;
  logic [7:0]    mem_q [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));

  // A pop frees the slot first, so a push into a full FIFO is still
  // accepted when a pop happens in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    valid_d  = valid_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The head register looks ahead at the next state. When the entry being
    // written this cycle becomes the head, it must bypass the memory.
    if (count_d != '0) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_data_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : 8N1 UART receiver with 16x oversampling, 3-sample majority
//                vote per bit and a small received-byte FIFO with a
//                valid/ready consumer interface.
//                Optional macro UART_RX_PARITY_EN adds an even-parity bit
//                between the data bits and the stop bit.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk_i          in   system clock, rising edge
//    reset_i        in   synchronous active-high reset
//    rxd_i          in   asynchronous serial line, idle high
//    rx_data_o      out  [7:0] head-of-FIFO byte
//    rx_valid_o     out  FIFO not empty
//    rx_ready_i     in   consumer pop (effective when rx_valid_o is high)
//    frame_err_o    out  one-cycle pulse, stop bit sampled low
//    parity_err_o   out  one-cycle pulse, parity mismatch (0 without macro)
//    overrun_o      out  sticky, a received byte was dropped (FIFO full)
//    overrun_clr_i  in   clears overrun_o (a simultaneous set wins)
//    busy_o         out  frame in progress
// ============================================================================
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  input  logic       overrun_clr_i,
  output logic       busy_o
);

  localparam int DIV   = uart_div_round(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  rx_state_e  state_q, state_d;

  logic       rxd_meta_q, rxd_meta_d;
  logic       rxd_sync_q, rxd_sync_d;
  logic       rxd_prev_q, rxd_prev_d;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic       samp_a_q, samp_a_d;
  logic       samp_b_q, samp_b_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;

  logic       push_q, push_d;
  logic [7:0] push_data_q, push_data_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
  logic       par_bad_q, par_bad_d;
  logic       parity_err_q, parity_err_d;
`endif

  logic       tick;
  logic       decide;
  logic       maj;
  logic       fall;
  logic       pop;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;

  assign fall   = rxd_prev_q & ~rxd_sync_q;
  assign tick   = (div_cnt_q == DIV_LAST);
  assign decide = tick & (tick_cnt_q == SAMPLE_TICK_2);
  assign maj    = (samp_a_q & samp_b_q) | (samp_a_q & rxd_sync_q) |
                  (samp_b_q & rxd_sync_q);

  assign pop  = rx_ready_i & ~fifo_empty;
  assign drop = push_q & fifo_full & ~pop;

  always_comb begin
    state_d     = state_q;
    rxd_meta_d  = rxd_i;
    rxd_sync_d  = rxd_meta_q;
    rxd_prev_d  = rxd_sync_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    tick_cnt_d  = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
    samp_a_d    = samp_a_q;
    samp_b_d    = samp_b_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    // Set takes priority over clear so a drop is never lost.
    overrun_d = drop ? 1'b1 : (overrun_clr_i ? 1'b0 : overrun_q);

    if (tick && (tick_cnt_q == SAMPLE_TICK_0)) samp_a_d = rxd_sync_q;
    if (tick && (tick_cnt_q == SAMPLE_TICK_1)) samp_b_d = rxd_sync_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          // Align the oversample grid to the start edge.
          state_d    = ST_START;
          div_cnt_d  = '0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (decide) state_d = maj ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide) begin
          shift_d   = {maj, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (decide) begin
          par_bad_d    = maj ^ (^shift_q);
          parity_err_d = maj ^ (^shift_q);
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (decide) begin
          if (maj) begin
            // Leave for IDLE at the sample point so the next start edge
            // can be caught during the second half of the stop bit.
`ifdef UART_RX_PARITY_EN
            push_d = ~par_bad_q;
`else
            push_d = 1'b1;
`endif
            push_data_d = shift_q;
            state_d     = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
      div_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      samp_a_q     <= 1'b1;
      samp_b_q     <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= 8'h00;
      push_q       <= 1'b0;
      push_data_q  <= 8'h00;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rxd_meta_q   <= rxd_meta_d;
      rxd_sync_q   <= rxd_sync_d;
      rxd_prev_q   <= rxd_prev_d;
      div_cnt_q    <= div_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_a_q     <= samp_a_d;
      samp_b_q     <= samp_b_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .valid_o     (rx_valid_o),
    .head_o      (rx_data_o)
  );

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

UART receiver for the board's serial console path: it samples the serial line that the light52 SoC transmits on (`pmod_e_2_txd_o`), recovers 8N1 bytes and queues them for the consumer. It is the receiving end of the SoC's UART transmit channel and is used both as an on-board loopback/monitor peripheral and as the self-checking receiver in the top-level bench. Each byte goes through 16x oversampling and a 3-sample majority vote before it is pushed into a small FIFO with a valid/ready output.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate in bit/s.
- `FIFO_DEPTH`, 4, number of received-byte entries; must be a power of two, 2 to 16.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `rxd_i`  in  1  asynchronous serial line; idle level 1.
- `rx_data_o`  out  8  head-of-FIFO byte.
- `rx_valid_o`  out  1  FIFO not empty.
- `rx_ready_i`  in  1  consumer pop; a pop occurs when `rx_valid_o & rx_ready_i`.
- `frame_err_o`  out  1  one-cycle pulse when a stop bit is sampled as 0.
- `parity_err_o`  out  1  one-cycle pulse on parity mismatch; tied to 0 without the macro.
- `overrun_o`  out  1  sticky; set when a byte is dropped because the FIFO is full.
- `overrun_clr_i`  in  1  clears `overrun_o`.
- `busy_o`  out  1  frame in progress (FSM not IDLE).

## Operation
- `rxd_i` passes through a 2-FF synchronizer. The synchronizer resets to 1.
- Tick generator:
  - Divider `DIV = round(CLK_HZ/(16*BAUD))`, which is 27 at the default parameters.
  - One-cycle `tick` is produced every DIV clocks.
  - The counter restarts at 0 on a falling edge detected in IDLE.
- Each bit is sampled at ticks 7, 8 and 9. The bit value is the majority of those 3 samples, and the decision is made at tick 9.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE -> START on a synchronized falling edge.
  - START: if the majority sample is 1, the start was false; go to IDLE with nothing reported. Otherwise go to DATA.
  - DATA: shift in 8 bits LSB first into a shift register. A 3-bit bit counter wraps 7 -> 0, then the FSM goes to PARITY or STOP.
  - STOP, sample 1: push the byte and return to IDLE on the same cycle, so the next start edge can be detected half a bit early.
  - STOP, sample 0: pulse `frame_err_o`, discard the byte, go to BREAK.
  - BREAK -> IDLE once the synchronized line reads 1.
- FIFO:
  - Push when STOP succeeds.
  - If the FIFO is full at push and no pop occurs that cycle: drop the byte and set `overrun_o`.
  - Push and pop in the same cycle while full: the pop takes effect first and the push is accepted, so count is unchanged.
  - Push and pop in the same cycle while empty: the byte is pushed; `rx_valid_o` rises next cycle.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
  - `overrun_o` set and `overrun_clr_i` in the same cycle: set wins.

## Timing
- Reset values:
  - `rx_data_o` = 0x00
  - `rx_valid_o` = 0
  - `frame_err_o` = 0
  - `parity_err_o` = 0
  - `overrun_o` = 0
  - `busy_o` = 0
  - FSM in IDLE, FIFO empty.
- Reset mid-frame abandons the frame with no error pulse. The next falling edge after reset starts a new frame.
- Latency from line to state: 2 clocks of synchronizer, then the falling edge is detected and `busy_o` rises on the next clock.
- Latency from the stop-bit tick-9 cycle to `rx_valid_o` = 1: exactly 2 clocks (push is registered, then the status is registered).
- `rx_data_o` is registered from the head entry. It is valid whenever `rx_valid_o` = 1 and updates the cycle after a pop.
- Error pulses are exactly 1 clock, registered in the cycle after the decision.
- Frame tolerance: ±3% baud mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined: a PARITY state follows DATA and samples an even-parity bit.
  - On mismatch: pulse `parity_err_o`, discard the byte, still pass through STOP, and do not push.
- Macro undefined: 8N1 only. There is no PARITY state and `parity_err_o` is constant 0.

## Structure
- Package `uart_pkg`:
  - FSM state encoding.
  - `UART_OVERSAMPLE` = 16.
  - Sample tick indices 7, 8 and 9.
  - A divider-rounding function.
- Sub-module `uart_rx_fifo`: synchronous FIFO with push, pop, full, empty and a registered head. The FSM and tick logic stay in `uart_rx_sampler`.

## Test plan
- Send 0x55, 0x00 and 0xFF back to back at 115200 with `rx_ready_i` = 1. Required: three pops with data 0x55, 0x00, 0xFF, and no error pulses.
- Drive `rxd_i` low for 4 ticks (about 108 clocks) then high. Required: no push, and `busy_o` returns to 0 by the end of the START bit period.
- Send 0xA3 with the stop bit forced to 0 for 2 bit times. Required: `frame_err_o` pulses once, no push, and the FSM stays in BREAK until the line goes high, then a following 0x3C is received correctly.
- Hold `rx_ready_i` = 0 and send 0x01 through 0x05. Required: 4 entries 0x01 to 0x04 are held, 0x05 is dropped, and `overrun_o` = 1 until `overrun_clr_i`.
- Assert `reset_i` for 1 clock during bit 4 of a frame. Required: all outputs return to their reset values and the next frame, 0x7E, is received correctly.
- With `UART_RX_PARITY_EN`, send 0xA5 with its parity bit set to 1 (wrong for even parity, since 0xA5 has four 1 bits). Required: `parity_err_o` pulses once and there is no push; 0xA5 with the correct parity bit (0) is pushed.
